// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter unit: divider state
// encoding and the default counter/fraction widths.
package perf_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int FRAC_BITS_DEF = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider. It produces one quotient bit per cycle,
// MSB first, for NUM_W cycles. The divisor must be non-zero when start is
// accepted. A start is accepted only in IDLE. done is high for the single
// cycle spent in DONE, when quotient is complete. abort returns to IDLE
// immediately.
module seq_divider
  import perf_pkg::*;
#(
  parameter int NUM_W = 40,
  parameter int DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W);

  div_state_e       state_q, state_d;
  logic [NUM_W-1:0] dvd_q;
  logic [NUM_W-1:0] quo_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic [DEN_W:0]   rem_n;
  logic             ge;
  logic             last_bit;
  logic             rem_top_unused;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    trial    = {rem_q, dvd_q[NUM_W-1]};
    diff     = trial - {1'b0, den_q};
    ge       = (trial >= {1'b0, den_q});
    rem_n    = ge ? diff : trial;
    last_bit = (cnt_q == CNT_W'(NUM_W - 1));
  end

  // The partial remainder is always below the divisor, so its top bit is zero.
  assign rem_top_unused = rem_n[DEN_W];

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_CALC;
      DIV_CALC: begin
        busy = 1'b1;
        if (last_bit) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // State register plus datapath. The datapath is cleared as well, so an
  // aborted division leaves no partial result behind.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst || abort) begin
      state_q <= DIV_IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && start) begin
        dvd_q <= num;
        den_q <= den;
        quo_q <= '0;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state_q == DIV_CALC) begin
        rem_q <= rem_n[DEN_W-1:0];
        quo_q <= {quo_q[NUM_W-2:0], ge};
        dvd_q <= {dvd_q[NUM_W-2:0], 1'b0};
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle/instruction performance counter with a continuously refreshed
// fixed-point CPI (cycles per instruction). The counters saturate.
// A dirty flag records counter changes since the last snapshot handed to
// the divider.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_instr,
  input  logic             end_instr,
  input  logic             halt,
  input  logic             clear,
  output logic [WIDTH-1:0] total_cycles,
  output logic [WIDTH-1:0] instr_count,
  output logic [WIDTH-1:0] cpi,
  output logic             cpi_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int NUM_W = WIDTH + FRAC_BITS;

  logic             running;
  logic             running_next;
  logic             dirty;
  logic             cyc_at_max;
  logic             ins_at_max;
  logic             cyc_step;
  logic             ins_step;
  logic             div_start;
  logic             div_done;
  logic             quo_over;
  logic [NUM_W-1:0] quotient;

  // Measurement window: halt has priority over a simultaneous start.
  always_comb begin
    running_next = running;
    if (halt)             running_next = 1'b0;
    else if (start_instr) running_next = 1'b1;
  end

  assign cyc_at_max = &total_cycles;
  assign ins_at_max = &instr_count;
  assign cyc_step   = running_next && !cyc_at_max;
  assign ins_step   = end_instr && !ins_at_max;
  assign div_start  = dirty && (instr_count != '0) && !busy;
  assign quo_over   = |quotient[NUM_W-1:WIDTH];

  // Counters, snapshot tracking and result capture; clear acts like reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      running      <= 1'b0;
      dirty        <= 1'b0;
      total_cycles <= '0;
      instr_count  <= '0;
      cpi          <= '0;
      cpi_valid    <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      running <= running_next;
      if (cyc_step) total_cycles <= total_cycles + WIDTH'(1);
      if (ins_step) instr_count  <= instr_count + WIDTH'(1);
      // A change on the snapshot edge itself keeps the flag set.
      dirty <= (dirty && !div_start) || cyc_step || ins_step;
      if (div_done) begin
        cpi       <= quo_over ? '1 : quotient[WIDTH-1:0];
        cpi_valid <= 1'b1;
      end
      ovf <= ovf | (running_next && cyc_at_max) | (end_instr && ins_at_max)
                 | (div_done && quo_over);
    end
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (clear),
    .start    (div_start),
    .num      ({total_cycles, {FRAC_BITS{1'b0}}}),
    .den      (instr_count),
    .busy     (busy),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: directed scenarios plus random pulses. A
// transaction-level model runs alongside the DUT. Each division is a job
// carrying a cycle countdown, and its result is plain integer division.
module tb_perf_counter_unit;

  localparam longint unsigned MAX = 64'hFFFF_FFFF;
  localparam int LAT = 41;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_instr = 1'b0;
  logic        end_instr = 1'b0;
  logic        halt = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] total_cycles, instr_count, cpi;
  logic        cpi_valid, busy, ovf;

  int checks = 0;
  int errors = 0;

  // Reference state.
  longint unsigned m_cyc, m_ins, m_cpi, m_num, m_den;
  bit m_run, m_dirty, m_valid, m_ovf, m_job;
  int m_left;

  perf_counter_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_instr  (start_instr),
    .end_instr    (end_instr),
    .halt         (halt),
    .clear        (clear),
    .total_cycles (total_cycles),
    .instr_count  (instr_count),
    .cpi          (cpi),
    .cpi_valid    (cpi_valid),
    .busy         (busy),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ins = 0; m_cpi = 0; m_num = 0; m_den = 1;
    m_run = 0; m_dirty = 0; m_valid = 0; m_ovf = 0; m_job = 0; m_left = 0;
  endtask

  // Applies one clock edge of the documented behaviour to the model.
  task automatic model_step();
    longint unsigned q, old_cyc, old_ins;
    bit go, run_n, chg;
    if (rst || clear) begin
      model_reset();
      return;
    end
    old_cyc = m_cyc;
    old_ins = m_ins;
    go    = !m_job && m_dirty && (m_ins != 0);
    run_n = halt ? 1'b0 : (start_instr ? 1'b1 : m_run);
    chg   = 0;
    if (m_job) begin
      m_left--;
      if (m_left == 0) begin
        q = m_num / m_den;
        if (q > MAX) begin m_cpi = MAX; m_ovf = 1; end
        else m_cpi = q;
        m_valid = 1;
        m_job   = 0;
      end
    end
    if (run_n) begin
      if (m_cyc == MAX) m_ovf = 1;
      else begin m_cyc++; chg = 1; end
    end
    if (end_instr) begin
      if (m_ins == MAX) m_ovf = 1;
      else begin m_ins++; chg = 1; end
    end
    if (go) begin
      m_job  = 1;
      m_left = LAT;
      m_num  = old_cyc * 256;
      m_den  = old_ins;
    end
    m_dirty = (m_dirty && !go) || chg;
    m_run   = run_n;
  endtask

  task automatic compare_all();
    check("cycles", total_cycles, m_cyc);
    check("instrs", instr_count, m_ins);
    check("cpi", cpi, m_cpi);
    check("valid", cpi_valid, m_valid);
    check("busy", busy, m_job);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic cycle(input bit r, input bit s, input bit e, input bit h, input bit c);
    rst = r; start_instr = s; end_instr = e; halt = h; clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pb, found;
    int n;
    model_reset();

    // Reset for two cycles: everything zero, no division without instructions.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_cycles", total_cycles, 0);
    check("rst_cpi", cpi, 0);
    check("rst_valid", cpi_valid, 0);
    idle(5);
    check("idle_valid", cpi_valid, 0);
    check("idle_busy", busy, 0);
    cycle(0, 0, 1, 0, 0);
    check("first_end_valid", cpi_valid, 0);

    // 40 cycles / 10 instructions -> 4.0.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    for (int i = 1; i <= 39; i++) cycle(0, 0, (i % 4) == 3, 0, 0);
    cycle(0, 0, 0, 1, 0);
    idle(100);
    check("s1_cycles", total_cycles, 40);
    check("s1_instrs", instr_count, 10);
    check("s1_cpi", cpi, 32'h400);
    check("s1_valid", cpi_valid, 1);

    // 3 cycles / 2 instructions -> 1.5, with same-cycle pulse combinations.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0);
    check("start_end_cycles", total_cycles, 1);
    check("start_end_instrs", instr_count, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    idle(2);
    check("halt_wins_cycles", total_cycles, 3);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      pb = busy;
      cycle(0, 0, 0, 0, 0);
      if (!pb && busy) found = 1;
    end
    check("snap_found", found, 1);
    n = 0;
    while (cpi != 32'h180 && n < 60) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    check("s2_latency", n, LAT);
    check("s2_cpi", cpi, 32'h180);

    // clear together with end_instr: clear wins.
    cycle(0, 0, 1, 0, 1);
    check("clear_end_instrs", instr_count, 0);
    check("clear_end_cpi", cpi, 0);
    check("clear_end_valid", cpi_valid, 0);

    // Saturation of the cycle counter and of the quotient.
    cycle(0, 1, 1, 0, 0);
    force dut.total_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.total_cycles;
    m_cyc = 64'hFFFF_FFFE;
    idle(5);
    check("sat_cycles", total_cycles, 32'hFFFF_FFFF);
    check("sat_ovf", ovf, 1);
    idle(100);
    check("sat_cpi", cpi, 32'hFFFF_FFFF);
    check("sat_valid", cpi_valid, 1);

    // clear during CALC aborts the division, and nothing restarts until end_instr.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (cpi_valid) found = 1;
    end
    check("abort_first_result", found, 1);
    idle(11);
    check("abort_pre_busy", busy, 1);
    cycle(0, 0, 0, 0, 1);
    check("abort_busy", busy, 0);
    check("abort_cpi", cpi, 0);
    check("abort_valid", cpi_valid, 0);
    idle(5);
    check("abort_stays_idle", busy, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("abort_restart", busy, 1);

    // Random pulse traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(999) < 5), ($urandom_range(99) < 10),
            ($urandom_range(99) < 30), ($urandom_range(99) < 3),
            ($urandom_range(99) < 1));
    end
    idle(90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
